// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between two requesters, the shared ALU and the response consumer.
// The slave modport is the arbiter's view; master is the environment's view.
`timescale 1ns/1ps
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;
    logic             resp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result,
        output resp_valid, resp_data, resp_id, resp_err,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result,
        input  resp_valid, resp_data, resp_id, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between two requesters,
// with a single tagged response channel and one operation outstanding.
`timescale 1ns/1ps
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_share_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(3'b010);
    localparam logic [OPW-1:0] OP_XNOR = OPW'(3'b101);

    function automatic logic op_is_illegal(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_XNOR: return 1'b0;
            default:         return 1'b1;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_id_q, resp_id_d;
    logic             resp_err_q, resp_err_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt0_s, gnt1_s;

    // Grant selection: only in IDLE; a tie goes to the requester that did not win last.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_q) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                gnt0_s = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_s) begin
                    alu_a_d      = bus.req0_a;
                    alu_b_d      = bus.req0_b;
                    alu_ctrl_d   = bus.req0_op;
                    resp_id_d    = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_EXEC;
                end else if (gnt1_s) begin
                    alu_a_d      = bus.req1_a;
                    alu_b_d      = bus.req1_b;
                    alu_ctrl_d   = bus.req1_op;
                    resp_id_d    = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                resp_data_d  = bus.alu_result;
                resp_err_d   = op_is_illegal(alu_ctrl_q);
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= {WIDTH{1'b0}};
            alu_b_q      <= {WIDTH{1'b0}};
            alu_ctrl_q   <= {OPW{1'b0}};
            resp_valid_q <= 1'b0;
            resp_data_q  <= {WIDTH{1'b0}};
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = gnt0_s;
    assign bus.req1_ready = gnt1_s;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural add/xnor ALU model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(8), .OPW(3)) bus ();

    // Reference ALU: add, xnor, everything else returns zero.
    always_comb begin
        case (bus.alu_ctrl)
            3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b101:  bus.alu_result = ~(bus.alu_a ^ bus.alu_b);
            default: bus.alu_result = 8'h00;
        endcase
    end

    alu_share_arbiter #(.WIDTH(8), .OPW(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic run_single(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic [7:0] exp_data, input logic exp_err);
        drive(id, a, b, op);
        #1;
        chk({tag, "_ready"}, id ? bus.req1_ready : bus.req0_ready, 1);
        chk({tag, "_other_ready"}, id ? bus.req0_ready : bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_alu_a"}, bus.alu_a, a);
        chk({tag, "_alu_b"}, bus.alu_b, b);
        chk({tag, "_alu_ctrl"}, bus.alu_ctrl, op);
        chk({tag, "_exec_valid"}, bus.resp_valid, 0);
        tick();
        chk({tag, "_resp_valid"}, bus.resp_valid, 1);
        chk({tag, "_resp_data"}, bus.resp_data, exp_data);
        chk({tag, "_resp_id"}, bus.resp_id, id);
        chk({tag, "_resp_err"}, bus.resp_err, exp_err);
        bus.resp_ready = 1'b1;
        tick();
        chk({tag, "_accepted"}, bus.resp_valid, 0);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00; bus.req0_op = 3'b000;
        bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00; bus.req1_op = 3'b000;
        bus.resp_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        reset_n = 1'b1;
        tick();

        run_single("add", 1'b0, 8'h3C, 8'h0F, 3'b010, 8'h4B, 1'b0);
        run_single("wrap", 1'b1, 8'hFF, 8'h02, 3'b010, 8'h01, 1'b0);
        run_single("xnor", 1'b1, 8'hA5, 8'h0F, 3'b101, 8'h55, 1'b0);

        // Round-robin: both requesters held valid, consumer always ready.
        drive(1'b0, 8'h01, 8'h02, 3'b010);
        drive(1'b1, 8'h10, 8'h20, 3'b101);
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_req0_ready", bus.req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_req1_ready", bus.req1_ready, (k % 2 == 1) ? 1 : 0);
            tick();
            chk("rr_exec_valid", bus.resp_valid, 0);
            tick();
            chk("rr_resp_valid", bus.resp_valid, 1);
            chk("rr_resp_id", bus.resp_id, k % 2);
            chk("rr_resp_data", bus.resp_data, (k % 2 == 0) ? 32'h03 : 32'hCF);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;

        // Backpressure: response held five cycles while req1 waits.
        drive(1'b0, 8'h11, 8'h22, 3'b010);
        #1;
        chk("bp_req0_ready", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        drive(1'b1, 8'h40, 8'h02, 3'b010);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", bus.resp_valid, 1);
            chk("bp_hold_data", bus.resp_data, 8'h33);
            chk("bp_hold_id", bus.resp_id, 0);
            chk("bp_hold_req0_ready", bus.req0_ready, 0);
            chk("bp_hold_req1_ready", bus.req1_ready, 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        #1;
        chk("bp_after_accept_valid", bus.resp_valid, 0);
        chk("bp_next_grant", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        chk("bp_second_valid", bus.resp_valid, 1);
        chk("bp_second_data", bus.resp_data, 8'h42);
        chk("bp_second_id", bus.resp_id, 1);
        bus.resp_ready = 1'b1;
        tick();
        chk("bp_second_accepted", bus.resp_valid, 0);

        // resp_ready with nothing pending must not create a response.
        tick();
        chk("idle_ready_ignored", bus.resp_valid, 0);
        bus.resp_ready = 1'b0;

        run_single("illegal", 1'b0, 8'h12, 8'h34, 3'b111, 8'h00, 1'b1);

        // Reset during EXEC: req1 wins the tie first, then req0 after reset.
        drive(1'b0, 8'h01, 8'h01, 3'b010);
        drive(1'b1, 8'h07, 8'h08, 3'b010);
        #1;
        chk("mid_tie_req1_ready", bus.req1_ready, 1);
        chk("mid_tie_req0_ready", bus.req0_ready, 0);
        tick();
        chk("mid_exec_alu_a", bus.alu_a, 8'h07);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.resp_valid, 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        chk("mid_rst_alu_ctrl", bus.alu_ctrl, 0);
        chk("mid_rst_data", bus.resp_data, 0);
        tick();
        chk("mid_rst_no_resp", bus.resp_valid, 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_req0_ready", bus.req0_ready, 1);
        chk("post_rst_req1_ready", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("post_rst_valid", bus.resp_valid, 1);
        chk("post_rst_id", bus.resp_id, 0);
        chk("post_rst_data", bus.resp_data, 8'h02);
        bus.resp_ready = 1'b1;
        tick();
        chk("post_rst_accepted", bus.resp_valid, 0);
        bus.resp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
